// File: rtl/iomem_uart_tx_if.sv
// Processor data-bus port for the iomem UART transmitter.
interface iomem_uart_tx_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wmask;
    logic            mem_rstrb;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata
    );
endinterface

// File: rtl/iomem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a one-entry holding register; reads return one cycle after rstrb.
// No bus stall: a write that finds the holding register full is dropped and sets sticky overrun.
module iomem_uart_tx #(
    parameter int XLEN     = 32,
    parameter int BAUD_DIV = 8
) (
    input  logic           clk,
    input  logic           reset,
    iomem_uart_tx_if.slave bus,
    output logic           tx
);
    localparam int             BW        = $clog2(BAUD_DIV) + 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            overrun_q, overrun_d;
    logic            tx_q, tx_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic sel_data, sel_status, wr_data, rd_status;
    logic baud_last, load, accept;
    logic unused_bits;

    assign sel_data   = bus.mem_addr[22] && (bus.mem_addr[21:0] == 22'h8);
    assign sel_status = bus.mem_addr[22] && (bus.mem_addr[21:0] == 22'h10);
    assign wr_data    = sel_data && bus.mem_wmask[0];
    assign rd_status  = bus.mem_rstrb && sel_status;
    assign baud_last  = (baud_q == BAUD_LAST);

    // The shifter drains the holding register from IDLE or at the final STOP cycle,
    // so a write landing on that same edge still finds room.
    assign load   = hold_full_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));
    assign accept = wr_data && (!hold_full_q || load);

    assign unused_bits = ^{bus.mem_addr[XLEN-1:23], bus.mem_wdata[XLEN-1:8], bus.mem_wmask[3:1]};

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (load) begin
                    shift_d = hold_q;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (load) begin
                        shift_d = hold_q;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // tx follows the next state so the line is a clean flop output.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;
        rdata_d     = rdata_q;

        if (accept) begin
            hold_d      = bus.mem_wdata[7:0];
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end

        if (wr_data && !accept) begin
            overrun_d = 1'b1;
        end else if (rd_status) begin
            overrun_d = 1'b0;
        end

        if (bus.mem_rstrb) begin
            rdata_d = '0;
            if (sel_status) begin
                rdata_d[2:0] = {overrun_q, hold_full_q, (state_q != S_IDLE)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_q        <= 1'b1;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
            tx_q        <= tx_d;
            rdata_q     <= rdata_d;
        end
    end

    assign tx            = tx_q;
    assign bus.mem_rdata = rdata_q;
endmodule

// File: tb/tb_iomem_uart_tx.sv
module tb_iomem_uart_tx;
    localparam int BD = 4;
    localparam logic [31:0] A_DATA = 32'h0040_0008;
    localparam logic [31:0] A_STAT = 32'h0040_0010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx;

    iomem_uart_tx_if #(.XLEN(32)) bus();

    iomem_uart_tx #(.XLEN(32), .BAUD_DIV(BD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb[$];
    int         starts[$];
    int         nframes = 0;
    int         cyc = 0;
    int         mcnt = 0;
    bit         mact = 1'b0;
    logic       tx_prev = 1'b1;
    logic [7:0] mbyte = '0;

    // Line monitor: decodes frames mid-bit and checks them against the scoreboard.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (tx === 1'b0 && tx_prev === 1'b1) begin
                mact = 1'b1;
                mcnt = 0;
                starts.push_back(cyc);
            end
        end else begin
            mcnt++;
            if (mcnt == BD/2) begin
                tests++;
                if (tx !== 1'b0) begin
                    fails++;
                    $display("FAIL start_bit: tx=%b, required 0", tx);
                end
            end else if (mcnt < 9*BD + BD/2 && (mcnt % BD) == BD/2) begin
                mbyte = {tx, mbyte[7:1]};
            end else if (mcnt == 9*BD + BD/2) begin
                tests++;
                if (tx !== 1'b1) begin
                    fails++;
                    $display("FAIL stop_bit: tx=%b, required 1", tx);
                end
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL frame_data: got unexpected byte %h, none required", mbyte);
                end else begin
                    automatic logic [7:0] exp_b = sb.pop_front();
                    if (mbyte !== exp_b) begin
                        fails++;
                        $display("FAIL frame_data: got %h, required %h", mbyte, exp_b);
                    end
                end
                nframes++;
                mact = 1'b0;
            end
        end
        tx_prev = tx;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d, input logic [3:0] m);
        bus.mem_addr  = a;
        bus.mem_wdata = {24'h0, d};
        bus.mem_wmask = m;
        @(negedge clk);
        bus.mem_wmask = 4'h0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
        bus.mem_addr  = a;
        bus.mem_rstrb = 1'b1;
        @(negedge clk);
        bus.mem_rstrb = 1'b0;
        v = bus.mem_rdata;
    endtask

    task automatic wait_frames(input int n, input string name);
        int budget = 0;
        while (nframes < n && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        tests++;
        if (nframes < n) begin
            fails++;
            $display("FAIL %s: frames seen %0d, required %0d (timeout)", name, nframes, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_gaps(input int n, input string name);
        int gap_ok = (starts.size() == n) ? 1 : 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != 10*BD) gap_ok = 0;
        end
        tests++;
        if (gap_ok != 1) begin
            fails++;
            $display("FAIL %s: %0d start bits with non-%0d-cycle spacing, required %0d back-to-back",
                     name, starts.size(), 10*BD, n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        int f0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: tx=%b, required 1", tx); end
        tests++;
        if (bus.mem_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: %h, required 0", bus.mem_rdata); end
        reset = 1'b0;
        @(negedge clk);

        bus_wr(A_DATA, 8'hC3, 4'h1);
        repeat (15) @(negedge clk);
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h1) begin fails++; $display("FAIL midframe_status: %h, required 1", v); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL midreset_tx: tx=%b, required 1", tx); end
        tests++;
        if (bus.mem_rdata !== 32'h0) begin fails++; $display("FAIL midreset_rdata: %h, required 0", bus.mem_rdata); end
        reset = 1'b0;
        @(negedge clk);
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL post_reset_status: %h, required 0", v); end
        f0 = nframes;
        repeat (60) @(negedge clk);
        tests++;
        if (nframes != f0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_idle: frames=%0d tx=%b, required %0d and 1", nframes, tx, f0);
        end
    endtask

    task automatic test_single();
        logic [31:0] v;
        int busy_cnt = 0;
        int f0 = nframes;
        starts.delete();
        sb.push_back(8'hA5);
        bus_wr(A_DATA, 8'hA5, 4'h1);
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL tx_before_start: tx=%b, required 1", tx); end
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h2) begin fails++; $display("FAIL status_hold_only: %h, required 2", v); end
        tests++;
        if (tx !== 1'b0) begin fails++; $display("FAIL tx_start_latency: tx=%b, required 0", tx); end
        for (int i = 0; i < 200; i++) begin
            bus_rd(A_STAT, v);
            if (v[0] === 1'b1) busy_cnt++;
            else break;
        end
        tests++;
        if (busy_cnt != 10*BD) begin fails++; $display("FAIL busy_cycles: %0d, required %0d", busy_cnt, 10*BD); end
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL status_after_frame: %h, required 0", v); end
        wait_frames(f0 + 1, "single_frame");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        int f0 = nframes;
        starts.delete();
        sb.push_back(8'h55);
        bus_wr(A_DATA, 8'h55, 4'h1);
        repeat (12) @(negedge clk);
        sb.push_back(8'h0F);
        bus_wr(A_DATA, 8'h0F, 4'h1);
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h3) begin fails++; $display("FAIL b2b_status: %h, required 3", v); end
        wait_frames(f0 + 2, "b2b_frames");
        check_gaps(2, "b2b_gap");
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        int f0 = nframes;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        bus_wr(A_DATA, 8'h11, 4'h1);
        bus_wr(A_DATA, 8'h22, 4'h1);
        bus_wr(A_DATA, 8'h33, 4'h1);
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h7) begin fails++; $display("FAIL overrun_status: %h, required 7", v); end
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h3) begin fails++; $display("FAIL overrun_cleared: %h, required 3", v); end
        wait_frames(f0 + 2, "overrun_frames");
        repeat (60) @(negedge clk);
        tests++;
        if (nframes != f0 + 2 || sb.size() != 0) begin
            fails++;
            $display("FAIL overrun_dropped: frames=%0d pending=%0d, required %0d and 0",
                     nframes - f0, sb.size(), 2);
        end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        bit low_seen = 1'b0;
        int f0 = nframes;
        bus_wr(32'h0000_0008, 8'hEE, 4'h1);
        bus_wr(32'h0040_0004, 8'hEE, 4'h1);
        bus_wr(A_DATA, 8'hEE, 4'b0010);
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        tests++;
        if (low_seen || nframes != f0) begin
            fails++;
            $display("FAIL decode_no_frame: low_seen=%0d frames=%0d, required 0 and 0", low_seen, nframes - f0);
        end
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL decode_status: %h, required 0", v); end

        sb.push_back(8'h3C);
        bus_wr(A_DATA, 8'h3C, 4'h1);
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h2) begin fails++; $display("FAIL decode_status_full: %h, required 2", v); end
        bus_rd(32'h0040_0020, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL read_unmapped: %h, required 0", v); end
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h1) begin fails++; $display("FAIL decode_status_busy: %h, required 1", v); end
        bus_rd(32'h0000_0010, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL read_ram_space: %h, required 0", v); end
        bus_rd(A_STAT, v);
        bus_rd(A_DATA, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL read_data_reg: %h, required 0", v); end
        wait_frames(f0 + 1, "decode_frame");
    endtask

    task automatic test_collision();
        logic [31:0] v;
        int f0 = nframes;
        starts.delete();
        sb.push_back(8'h81);
        sb.push_back(8'h42);
        sb.push_back(8'hE7);
        bus_wr(A_DATA, 8'h81, 4'h1);
        repeat (4) @(negedge clk);
        bus_wr(A_DATA, 8'h42, 4'h1);
        // Lands exactly on the last STOP cycle of the first frame.
        repeat (35) @(negedge clk);
        bus_wr(A_DATA, 8'hE7, 4'h1);
        bus_rd(A_STAT, v);
        tests++;
        if (v !== 32'h3) begin fails++; $display("FAIL collision_status: %h, required 3", v); end
        wait_frames(f0 + 3, "collision_frames");
        check_gaps(3, "collision_gap");
    endtask

    initial begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = 4'h0;
        bus.mem_rstrb = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_decode();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iomem_uart_tx.md
# iomem_uart_tx

Memory-mapped UART transmitter that sits on the processor's data bus as a responder in the iomem window (address bit 22 set), alongside the LED register at offset 'h4. Software writes a byte to the data register. The block buffers it in a one-entry holding register, then serialises it as an 8N1 frame on `tx`. A status register readable over the same bus reports busy, full and overrun, so firmware can poll before writing.

## Interface
- `XLEN`, 32: bus data/address width.
- `BAUD_DIV`, 8: clock cycles per serial bit; legal range 2..65535.
- `clk`  in  1  system clock (the divided clock the processor runs on).
- `reset`  in  1  synchronous, active-high reset.
- `mem_addr`  in  XLEN  byte address from processor.
- `mem_wdata`  in  XLEN  write data.
- `mem_wmask`  in  4  byte write enables; any bit set is a write strobe.
- `mem_rstrb`  in  1  read strobe.
- `mem_rdata`  out  XLEN  registered read data; zero unless the last read hit this block.
- `tx`  out  1  serial output, idle high.

## Operation
- Select: `mem_addr[22]` = 1 and `mem_addr[21:0]` equal to one of the register offsets below. Other addresses are ignored.
- DATA register, offset 'h8:
  - A write with `mem_wmask[0]`=1 offers `mem_wdata[7:0]`.
  - Accepted if hold is empty, or if the shifter takes the hold byte in the same cycle. Accepted: hold is loaded, hold_full=1.
  - Otherwise the byte is dropped and overrun=1.
  - Writes with `mem_wmask[0]`=0 are ignored. Reads return 0.
- STATUS register, offset 'h10, read-only:
  - Bit 0 = busy (shifter not IDLE). Bit 1 = hold_full. Bit 2 = overrun (sticky). Other bits are 0.
  - A status read clears overrun. If an overrun event occurs in the same cycle as the read, the set wins.
  - Writes are ignored.
- Shifter FSM: IDLE, START, DATA, STOP.
  - IDLE: if hold_full, load shift register from hold, clear hold_full, go to START.
  - START: tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: tx = shift[0] for BAUD_DIV cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles. At the last STOP cycle, if hold_full, reload and go directly to START. Otherwise go to IDLE.
- Counters:
  - Baud counter is `$clog2(BAUD_DIV)`+1 bits wide. It counts 0..BAUD_DIV-1 and resets on every state or bit change.
  - Bit index is 3 bits.
- Reset, from any state including mid-frame:
  - Outputs: tx=1, `mem_rdata`=0.
  - Internal: FSM IDLE, hold_full=0, overrun=0, counters 0.
  - A partial frame is abandoned. No stop bit is emitted.

## Timing
- Read latency is 1 cycle. Address is sampled at the edge where `mem_rstrb`=1, and `mem_rdata` is valid after that edge. The value holds until the next `mem_rstrb`.
  - Read to an unselected address: `mem_rdata`=0 after the edge.
  - The status value returned is the one sampled at the rstrb edge, before the same-edge clear.
- Write takes effect at the edge where the write strobe is high.
  - With FSM IDLE and hold empty, a write at edge N sets hold_full at N.
  - At edge N+1 the FSM enters START and tx goes low.
  - Busy reads 1 from N+1.
- Frame length is exactly 10*BAUD_DIV cycles from the tx falling edge to the end of the stop bit.
- Back-to-back: a byte held at the end of STOP starts its start bit on the next cycle, with no idle gap.
- hold_full clears on the edge the shifter loads. A write in that same cycle is accepted, with no overrun.
- `tx` is registered and glitch-free.

## Test plan
- Reset: assert `reset` for 2 cycles mid-frame -> tx=1, `mem_rdata`=0. A subsequent status read returns 'h0.
- Single byte, BAUD_DIV=4: write 'hA5 to 'h400008 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Busy=1 for 40 cycles, then status reads 'h0.
- Back-to-back: write 'h55, then write 'h0F while the first frame is in DATA -> status reads 'h3. Second start bit begins the cycle after the first stop bit ends; total 80 cycles of activity with no gap.
- Overrun: write 3 bytes in consecutive cycles while idle.
  - Status read returns 'h7 (busy, full, overrun).
  - Next status read returns 'h3.
  - The third byte never appears on tx.
- Bus decode: write to 'h000008 (RAM space), to 'h400004 (LEDS), and with wmask='b0010 to 'h400008 -> no frame, tx stays 1. Read of 'h400020 -> `mem_rdata`=0.
- Load/write collision: hold full, and a new write lands in the final STOP cycle of the current frame -> accepted without overrun, and both bytes are transmitted in order.
